// File: rtl/qmc_fx_pkg.sv
// Shared fixed-point definitions for the LSM regression path: default Q format,
// control states and signed saturation helpers.
package qmc_fx_pkg;
    localparam int FX_WIDTH     = 32;
    localparam int FX_FRAC      = 16;
    localparam int FX_ACC_WIDTH = 48;
    // Working width for saturation checks; must cover 2*WIDTH and ACC_WIDTH.
    localparam int SAT_W        = 128;
    localparam logic [1:0] DRAIN_CYC = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    function automatic logic signed [SAT_W-1:0] fx_lim(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic fx_ovf(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] hi;
        hi = fx_lim(w);
        return (v > hi) || (v < ~hi);
    endfunction

    function automatic logic signed [SAT_W-1:0] fx_sat(input logic signed [SAT_W-1:0] v, input int w);
        logic signed [SAT_W-1:0] hi;
        hi = fx_lim(w);
        if (v > hi) return hi;
        if (v < ~hi) return ~hi;
        return v;
    endfunction
endpackage

// File: rtl/fx_mul_sat.sv
// Signed Q multiply: full-precision product, arithmetic shift by FRAC, saturate to WIDTH.
module fx_mul_sat
    import qmc_fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int FRAC  = FX_FRAC
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] p_o,
    output logic                    ovf_o
);
    logic signed [2*WIDTH-1:0] ax, bx, full;
    logic signed [SAT_W-1:0]   wide;

    always_comb begin
        ax    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
        bx    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
        full  = ax * bx;
        // >>> on a signed operand truncates toward -inf
        wide  = {{(SAT_W-2*WIDTH){full[2*WIDTH-1]}}, full >>> FRAC};
        p_o   = WIDTH'(fx_sat(wide, WIDTH));
        ovf_o = fx_ovf(wide, WIDTH);
    end
endmodule

// File: rtl/normal_eq_accum3.sv
// Accumulates the 3x3 normal equations X'X, X'y for basis {1,x,x^2} over the ITM
// samples of a batch, then holds the result until the solver takes it.
module normal_eq_accum3
    import qmc_fx_pkg::*;
#(
    parameter int WIDTH     = FX_WIDTH,
    parameter int FRAC      = FX_FRAC,
    parameter int ACC_WIDTH = FX_ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic                    in_itm,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9*WIDTH-1:0]      A_flat,
    output logic [3*WIDTH-1:0]      B_flat,
    output logic [31:0]             out_count,
    output logic                    overflow
);
    localparam int NSUM = 7;  // Sx, Sx2, Sx3, Sx4, Sy, Sxy, Sx2y

    typedef logic signed [WIDTH-1:0]     fx_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [SAT_W-1:0]     wide_t;

    state_t     state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic       accept, hs, enter_hold;

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign accept     = in_valid && in_ready;
    assign hs         = out_valid && out_ready;
    assign enter_hold = (state_q == DRAIN) && (drain_q == DRAIN_CYC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE:  state_d = ACCUM;
            ACCUM: if (accept && in_last) begin
                state_d = DRAIN;
                drain_d = '0;
            end
            DRAIN: if (drain_q == DRAIN_CYC) state_d = HOLD;
                   else drain_d = drain_q + 2'd1;
            HOLD:  if (out_ready) state_d = ACCUM;
            default: state_d = IDLE;
        endcase
    end

    // Input capture, products x^2/xy, then x^3/x^4/x^2y; valid bits only for ITM samples.
    logic [2:0] vld_pipe_q;
    fx_t        s0_x_q, s0_y_q, s1_x_q, s1_y_q, s1_x2_q, s1_xy_q;
    fx_t        s2_t_q [NSUM];
    fx_t        p_x2, p_xy, p_x3, p_x4, p_x2y;
    logic [4:0] mov;

    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_x2  (.a_i(s0_x_q),  .b_i(s0_x_q),  .p_o(p_x2),  .ovf_o(mov[0]));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_xy  (.a_i(s0_x_q),  .b_i(s0_y_q),  .p_o(p_xy),  .ovf_o(mov[1]));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_x3  (.a_i(s1_x2_q), .b_i(s1_x_q),  .p_o(p_x3),  .ovf_o(mov[2]));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_x4  (.a_i(s1_x2_q), .b_i(s1_x2_q), .p_o(p_x4),  .ovf_o(mov[3]));
    fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_x2y (.a_i(s1_x2_q), .b_i(s1_y_q),  .p_o(p_x2y), .ovf_o(mov[4]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s0_x_q <= '0; s0_y_q <= '0;
            s1_x_q <= '0; s1_y_q <= '0; s1_x2_q <= '0; s1_xy_q <= '0;
            for (int i = 0; i < NSUM; i++) s2_t_q[i] <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], accept && in_itm};
            if (accept) begin
                s0_x_q <= in_x;
                s0_y_q <= in_y;
            end
            s1_x_q    <= s0_x_q;
            s1_y_q    <= s0_y_q;
            s1_x2_q   <= p_x2;
            s1_xy_q   <= p_xy;
            s2_t_q[0] <= s1_x_q;
            s2_t_q[1] <= s1_x2_q;
            s2_t_q[2] <= p_x3;
            s2_t_q[3] <= p_x4;
            s2_t_q[4] <= s1_y_q;
            s2_t_q[5] <= s1_xy_q;
            s2_t_q[6] <= p_x2y;
        end
    end

    acc_t        acc_q [NSUM];
    acc_t        acc_d [NSUM];
    wide_t       acc_sum [NSUM];
    wide_t       res [8];
    fx_t         o_v [8];
    logic [31:0] cnt_q, cnt_out_q;
    logic        acc_ovf, out_ovf, ovf_q;
    logic [8:0][WIDTH-1:0] a_q;
    logic [2:0][WIDTH-1:0] b_q;

    always_comb begin
        acc_ovf = 1'b0;
        for (int i = 0; i < NSUM; i++) begin
            acc_sum[i] = {{(SAT_W-ACC_WIDTH){acc_q[i][ACC_WIDTH-1]}}, acc_q[i]}
                       + {{(SAT_W-WIDTH){s2_t_q[i][WIDTH-1]}}, s2_t_q[i]};
            acc_d[i]   = ACC_WIDTH'(fx_sat(acc_sum[i], ACC_WIDTH));
            acc_ovf    = acc_ovf | fx_ovf(acc_sum[i], ACC_WIDTH);
        end
    end

    // res[0] is n in Q format, res[1..7] follow the accumulator order.
    always_comb begin
        out_ovf = 1'b0;
        res[0]  = {{(SAT_W-32){1'b0}}, cnt_q} << FRAC;
        for (int i = 0; i < NSUM; i++)
            res[i+1] = {{(SAT_W-ACC_WIDTH){acc_q[i][ACC_WIDTH-1]}}, acc_q[i]};
        for (int i = 0; i < 8; i++) begin
            o_v[i]  = WIDTH'(fx_sat(res[i], WIDTH));
            out_ovf = out_ovf | fx_ovf(res[i], WIDTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || hs) begin
            for (int i = 0; i < NSUM; i++) acc_q[i] <= '0;
            cnt_q     <= '0;
            cnt_out_q <= '0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            if (vld_pipe_q[2]) begin
                acc_q <= acc_d;
                if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
            end
            ovf_q <= ovf_q | (vld_pipe_q[0] & (mov[0] | mov[1])) | (vld_pipe_q[1] & (|mov[4:2]))
                   | (vld_pipe_q[2] & acc_ovf) | (enter_hold & out_ovf);
            if (enter_hold) begin
                a_q       <= {o_v[4], o_v[3], o_v[2], o_v[3], o_v[2], o_v[1], o_v[2], o_v[1], o_v[0]};
                b_q       <= {o_v[7], o_v[6], o_v[5]};
                cnt_out_q <= cnt_q;
            end
        end
    end

    assign A_flat    = a_q;
    assign B_flat    = b_q;
    assign out_count = cnt_out_q;
    assign overflow  = ovf_q;
endmodule
